// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte-addressed data memory with RISC-V B/H/W load/store sizing
// Writes commit at the accept edge; the response is registered and held under back-pressure.
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int INIT_INDEX  = 1,
    parameter int ERRCNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [31:0]         req_addr_i,
    input  logic [31:0]         req_wdata_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [31:0]         resp_rdata_o,
    output logic                resp_err_o,
    output logic [ERRCNT_W-1:0] err_count_o
);
    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] SZ_W  = 2'b10;

    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    logic             accept;
    logic             req_err;
    logic             wr_en;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic [3:0]       byte_en;
    logic [31:0]      wr_lanes;
    logic [31:0]      rd_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic [31:0]      rd_words [DEPTH_WORDS];

    assign lane        = req_addr_i[1:0];
    assign idx         = req_addr_i[IDX_W+1:2];
    assign req_ready_o = !resp_valid_q || resp_ready_i;
    assign accept      = req_valid_i && req_ready_o && !rst_i;
    assign wr_en       = accept && req_we_i && !req_err;

    always_comb begin
        req_err = 1'b0;
        case (req_size_i)
            SZ_B:    req_err = 1'b0;
            SZ_H:    req_err = lane[0];
            SZ_W:    req_err = (lane != 2'b00);
            default: req_err = 1'b1;
        endcase
        if (req_addr_i[31:2] >= 30'(DEPTH_WORDS)) begin
            req_err = 1'b1;
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target lanes.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = req_wdata_i;
        case (req_size_i)
            SZ_B: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{req_wdata_i[7:0]}};
            end
            SZ_H: begin
                byte_en  = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{req_wdata_i[15:0]}};
            end
            SZ_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
        logic [31:0] word_q = (INIT_INDEX != 0) ? 32'(g) : 32'd0;

        always_ff @(posedge clk_i) begin
            if (wr_en && (idx == IDX_W'(g))) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) begin
                        word_q[8*b +: 8] <= wr_lanes[8*b +: 8];
                    end
                end
            end
        end

        assign rd_words[g] = word_q;
    end

    assign rd_word = rd_words[idx];
    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = rd_word;
        case (req_size_i)
            SZ_B:    ld_data = {{24{ld_byte[7] & !req_unsigned_i}}, ld_byte};
            SZ_H:    ld_data = {{16{ld_half[15] & !req_unsigned_i}}, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        err_count_d  = err_count_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_err_d   = req_err;
            resp_rdata_d = (req_we_i || req_err) ? 32'd0 : ld_data;
            if (req_err && (err_count_q != {ERRCNT_W{1'b1}})) begin
                err_count_d = err_count_q + ERRCNT_W'(1);
            end
        end else if (resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign err_count_o  = err_count_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - self-checking bench for data_mem_lsu
// Cycle-level behavioural model plus directed vectors with literal expectations.
module tb_data_mem_lsu;
    localparam int DEPTH = 256;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [CW-1:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    data_mem_lsu #(.DEPTH_WORDS(DEPTH), .INIT_INDEX(1), .ERRCNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err), .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [DEPTH];
    logic        m_valid;
    logic [31:0] m_rdata;
    logic        m_err;
    int          m_cnt;

    initial for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'(i);

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if ((a % nbytes(sz)) != 0) return 1'b1;
        return (a / 4) >= DEPTH;
    endfunction

    function automatic logic [31:0] load_val(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] w);
        logic [63:0] v;
        int bits;
        bits = 8 * nbytes(sz);
        v = (64'(w) >> (8 * (a % 4))) & ((64'd1 << bits) - 64'd1);
        if (!uns && bits < 32 && ((v >> (bits - 1)) & 64'd1) == 64'd1) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    function automatic logic [31:0] store_word(input logic [1:0] sz, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [31:0] old);
        logic [31:0] w;
        int lane;
        w = old;
        lane = int'(a % 4);
        for (int k = 0; k < nbytes(sz); k++) w[8*(lane+k) +: 8] = wd[8*k +: 8];
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_rdata <= 32'd0;
            m_err   <= 1'b0;
            m_cnt   <= 0;
        end else if (req_valid && (!m_valid || resp_ready)) begin
            m_valid <= 1'b1;
            m_err   <= is_bad(req_size, req_addr);
            if (is_bad(req_size, req_addr)) begin
                m_rdata <= 32'd0;
                m_cnt   <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end else if (req_we) begin
                m_rdata <= 32'd0;
                mem_m[req_addr / 4] <= store_word(req_size, req_addr, req_wdata, mem_m[req_addr / 4]);
            end else begin
                m_rdata <= load_val(req_size, req_unsigned, req_addr, mem_m[req_addr / 4]);
            end
        end else if (resp_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(!m_valid || resp_ready));
            chk("resp_valid", 32'(resp_valid), 32'(m_valid));
            chk("err_count", 32'(err_count), 32'(m_cnt));
            if (m_valid) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", 32'(resp_err), 32'(m_err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
        bit done;
        done = 1'b0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        for (int t = 0; t < 20 && !done; t++) begin
            done = req_ready;
            step();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: request at 0x%08h never accepted", a);
        end
        req_valid = 1'b0;
    endtask

    task automatic resp_is(input string name, input logic [31:0] rdata, input logic err);
        chk({name, "_valid"}, 32'(resp_valid), 32'd1);
        chk({name, "_rdata"}, resp_rdata, rdata);
        chk({name, "_err"}, 32'(resp_err), 32'(err));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
        step(); step();
        chk_en = 1'b1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        step();

        req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);          resp_is("lw_10", 32'h4, 1'b0);
        req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0);         resp_is("lw_last", 32'hFF, 1'b0);

        req(1'b1, 2'd2, 1'b0, 32'h20, 32'h8000_00F0);  resp_is("sw_20", 32'h0, 1'b0);
        req(1'b0, 2'd0, 1'b0, 32'h20, 32'd0);          resp_is("lb_20", 32'hFFFF_FFF0, 1'b0);
        req(1'b0, 2'd0, 1'b1, 32'h20, 32'd0);          resp_is("lbu_20", 32'h0000_00F0, 1'b0);
        req(1'b0, 2'd1, 1'b0, 32'h22, 32'd0);          resp_is("lh_22", 32'hFFFF_8000, 1'b0);
        req(1'b0, 2'd1, 1'b1, 32'h22, 32'd0);          resp_is("lhu_22", 32'h0000_8000, 1'b0);

        req(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_00AB);  resp_is("sb_41", 32'h0, 1'b0);
        req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0);          resp_is("lw_40", 32'h0000_AB10, 1'b0);
        req(1'b1, 2'd1, 1'b0, 32'h52, 32'h1234_BEEF);  resp_is("sh_52", 32'h0, 1'b0);
        req(1'b0, 2'd2, 1'b0, 32'h50, 32'd0);          resp_is("lw_50", 32'hBEEF_0014, 1'b0);

        req(1'b0, 2'd2, 1'b0, 32'h02, 32'd0);          resp_is("err_lw_mis", 32'h0, 1'b1);
        req(1'b0, 2'd1, 1'b0, 32'h01, 32'd0);          resp_is("err_lh_mis", 32'h0, 1'b1);
        req(1'b1, 2'd3, 1'b0, 32'h00, 32'hFFFF_FFFF);  resp_is("err_size", 32'h0, 1'b1);
        req(1'b1, 2'd2, 1'b0, 32'h400, 32'hFFFF_FFFF); resp_is("err_range", 32'h0, 1'b1);
        chk("err_count_4", 32'(err_count), 32'd4);
        req(1'b0, 2'd2, 1'b0, 32'h00, 32'd0);          resp_is("lw_0_nowr", 32'h0, 1'b0);
        req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0);         resp_is("lw_last_nowr", 32'hFF, 1'b0);

        // back-pressure: A accepted, B stalls three cycles, then B and C stream out
        step();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        step();
        resp_is("bp_a", 32'h4, 1'b0);
        req_addr = 32'h14;
        for (int c = 0; c < 3; c++) begin
            chk("bp_ready_low", 32'(req_ready), 32'd0);
            step();
            resp_is("bp_hold", 32'h4, 1'b0);
        end
        resp_ready = 1'b1;
        step();
        resp_is("bp_b", 32'h5, 1'b0);
        req_addr = 32'h18;
        step();
        resp_is("bp_c", 32'h6, 1'b0);
        req_valid = 1'b0;
        step();
        chk("bp_drain", 32'(resp_valid), 32'd0);

        for (int e = 0; e < CMAX - 4 + 2; e++) req(1'b0, 2'd1, 1'b0, 32'h01, 32'd0);
        chk("err_count_sat", 32'(err_count), 32'(CMAX));

        // reset with a pending response and a concurrent store that must not land
        req(1'b0, 2'd2, 1'b0, 32'h30, 32'd0);          resp_is("lw_30", 32'hC, 1'b0);
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
        step();
        chk("rst_drop_valid", 32'(resp_valid), 32'd0);
        chk("rst_clr_count", 32'(err_count), 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        step();
        req(1'b0, 2'd2, 1'b0, 32'h30, 32'd0);          resp_is("lw_30_after_rst", 32'hC, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
